// File: rtl/lfsr_3bits_checker.sv
// Receive-side checker for the 3-bit LFSR word stream: HUNT/SYNC/LOCKED acquisition, then flywheel error detection.
// Latency: locked/err/err_cnt are registered and update on the same edge that samples the word.
// Backpressure: none; words are consumed only on edges with vld=1, and vld=0 edges hold all state.
module lfsr_3bits_checker #(
    parameter int N          = 3,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             vld,
    input  logic [N-1:0]     din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int BR_W = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] c);
        lfsr_next = {c[1] ^ c[2], c[0], c[2]};
    endfunction

    state_t           r_state;
    logic [N-1:0]     r_exp;
    logic [MC_W-1:0]  r_match_cnt;
    logic [BR_W-1:0]  r_bad_run;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    state_t           w_state_nxt;
    logic [N-1:0]     w_exp_nxt;
    logic [MC_W-1:0]  w_match_nxt;
    logic [BR_W-1:0]  w_bad_nxt;
    logic             w_err_nxt;
    logic             w_err_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_din_zero;
    logic             w_din_hit;

    assign w_din_zero = (din == '0);
    assign w_din_hit  = (din == r_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_match_nxt = r_match_cnt;
        w_bad_nxt   = r_bad_run;
        w_err_nxt   = 1'b0;
        w_err_inc   = 1'b0;
        if (vld) begin
            case (r_state)
                HUNT: begin
                    if (!w_din_zero) begin
                        w_exp_nxt   = lfsr_next(din);
                        w_match_nxt = MC_W'(1);
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (w_din_zero) begin
                        w_state_nxt = HUNT;
                    end else if (w_din_hit) begin
                        w_exp_nxt = lfsr_next(din);
                        if (int'(r_match_cnt) + 1 == LOCK_CNT) begin
                            w_state_nxt = LOCKED;
                            w_bad_nxt   = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + MC_W'(1);
                        end
                    end else begin
                        // Re-seed from the new word; SYNC mismatches are not errors.
                        w_exp_nxt   = lfsr_next(din);
                        w_match_nxt = MC_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction runs from its own state, never from din.
                    w_exp_nxt = lfsr_next(r_exp);
                    if (w_din_hit) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_err_inc = 1'b1;
                        w_bad_nxt = r_bad_run + BR_W'(1);
                        if (int'(r_bad_run) + 1 == UNLOCK_CNT) begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt = r_err_cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            w_cnt_nxt = r_err_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= HUNT;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_bad_run   <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_bad_run   <= w_bad_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err       <= w_err_nxt;
            r_err_cnt   <= w_cnt_nxt;
        end
    end

    assign locked  = r_locked;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lfsr_3bits_checker.sv
// Directed bench for lfsr_3bits_checker: an 8-bit counter instance and a 2-bit counter instance share stimulus.
module tb_lfsr_3bits_checker;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       vld;
    logic [2:0] din;
    logic       clr;
    logic       locked, err;
    logic [7:0] err_cnt;
    logic       locked2, err2;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad   = 0;
    logic [2:0] w;

    lfsr_3bits_checker #(.N(3), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vld(vld), .din(din), .clr(clr),
        .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    lfsr_3bits_checker #(.N(3), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vld(vld), .din(din), .clr(clr),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [2:0] nxt(input logic [2:0] c);
        nxt = {c[1] ^ c[2], c[0], c[2]};
    endfunction

    function automatic logic [2:0] badw(input logic [2:0] g);
        badw = (g == 3'b001) ? 3'b010 : (g ^ 3'b001);
    endfunction

    task automatic send(input logic v, input logic [2:0] d, input logic c);
        vld = v;
        din = d;
        clr = c;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        vld = 1'b0;
        din = 3'b000;
        clr = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vld = 1'($urandom);
            din = 3'($urandom);
            clr = 1'b0;
            @(posedge sys_clk);
            #1;
            total++;
            if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
                bad++;
                $display("FAIL rst_outputs: got locked=%b err=%b cnt=%0d want 0 0 0", locked, err, err_cnt);
            end
        end
        sys_rst_n = 1'b1;
        send(1'b0, 3'b000, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL rst_release: got locked=%b want 0", locked);
        end
    endtask

    task automatic test_acquire();
        send(1'b1, 3'b001, 1'b0);
        send(1'b1, 3'b010, 1'b0);
        send(1'b1, 3'b100, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL acq_early: got locked=%b want 0 after 3 words", locked);
        end
        send(1'b1, 3'b101, 1'b0);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL acq_lock: got locked=%b want 1 after 101", locked);
        end
        w = 3'b111;
        for (int i = 0; i < 21; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                send(1'b0, 3'($urandom), 1'b0);
                total++;
                if (err !== 1'b0 || locked !== 1'b1) begin
                    bad++;
                    $display("FAIL acq_gap: got err=%b locked=%b want 0 1", err, locked);
                end
            end
            send(1'b1, w, 1'b0);
            w = nxt(w);
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL acq_run: got err=%b want 0 at word %0d", err, i);
            end
        end
        total++;
        if (err_cnt !== 8'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL acq_end: got cnt=%0d locked=%b want 0 1", err_cnt, locked);
        end
    endtask

    task automatic test_single_hit();
        send(1'b1, 3'b110, 1'b0);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL hit_err: got err=%b cnt=%0d locked=%b want 1 1 1", err, err_cnt, locked);
        end
        send(1'b1, 3'b011, 1'b0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL hit_pulse: got err=%b want 0 after good word", err);
        end
        send(1'b1, 3'b110, 1'b0);
        total++;
        if (err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL hit_flywheel: got err=%b cnt=%0d locked=%b want 0 1 1", err, err_cnt, locked);
        end
        w = 3'b001;
    endtask

    task automatic test_loss();
        for (int i = 0; i < 3; i++) begin
            send(1'b1, badw(w), 1'b0);
            w = nxt(w);
            total++;
            if (err !== 1'b1 || err_cnt !== 8'(2 + i) || locked !== ((i < 2) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL loss_bad%0d: got err=%b cnt=%0d locked=%b want 1 %0d %b",
                         i, err, err_cnt, locked, 2 + i, (i < 2));
            end
        end
        send(1'b1, 3'b011, 1'b0);
        send(1'b1, 3'b110, 1'b0);
        send(1'b1, 3'b001, 1'b0);
        total++;
        if (locked !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL relock_early: got locked=%b err=%b want 0 0", locked, err);
        end
        send(1'b1, 3'b010, 1'b0);
        total++;
        if (locked !== 1'b1 || err_cnt !== 8'd4) begin
            bad++;
            $display("FAIL relock: got locked=%b cnt=%0d want 1 4", locked, err_cnt);
        end
    endtask

    task automatic test_lockup();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 3'b000, 1'b0);
            total++;
            if (locked !== 1'b0 || err_cnt !== 8'd0 || err !== 1'b0) begin
                bad++;
                $display("FAIL zero_hunt: got locked=%b cnt=%0d err=%b want 0 0 0", locked, err_cnt, err);
            end
        end
        send(1'b1, 3'b101, 1'b0);
        send(1'b1, 3'b111, 1'b0);
        send(1'b1, 3'b000, 1'b0);
        send(1'b1, 3'b011, 1'b0);
        send(1'b1, 3'b110, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL sync_zero_a: got locked=%b want 0", locked);
        end
        send(1'b1, 3'b001, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL sync_zero_b: got locked=%b want 0", locked);
        end
        send(1'b1, 3'b010, 1'b0);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL sync_zero_relock: got locked=%b want 1", locked);
        end
    endtask

    task automatic test_sat_clr();
        do_reset();
        send(1'b1, 3'b001, 1'b0);
        send(1'b1, 3'b010, 1'b0);
        send(1'b1, 3'b100, 1'b0);
        send(1'b1, 3'b101, 1'b0);
        w = 3'b111;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, badw(w), 1'b0);
            w = nxt(w);
            total++;
            if (err2 !== 1'b1 || err_cnt2 !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
                bad++;
                $display("FAIL sat_bad%0d: got err=%b cnt=%0d want 1 %0d", i, err2, err_cnt2, (i < 3) ? i + 1 : 3);
            end
            send(1'b1, w, 1'b0);
            w = nxt(w);
        end
        total++;
        if (err_cnt2 !== 2'd3 || err_cnt !== 8'd5 || locked2 !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold: got cnt2=%0d cnt=%0d locked=%b want 3 5 1", err_cnt2, err_cnt, locked2);
        end
        send(1'b1, badw(w), 1'b1);
        w = nxt(w);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd0 || err_cnt2 !== 2'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL clr_err: got err=%b cnt=%0d cnt2=%0d locked=%b want 1 0 0 1",
                     err, err_cnt, err_cnt2, locked);
        end
        send(1'b1, w, 1'b0);
        w = nxt(w);
        total++;
        if (err_cnt !== 8'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL clr_after: got cnt=%0d locked=%b want 0 1", err_cnt, locked);
        end
        #1;
        sys_rst_n = 1'b0;
        #1;
        total++;
        if (locked !== 1'b0 || locked2 !== 1'b0 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_rst: got locked=%b locked2=%b cnt=%0d want 0 0 0", locked, locked2, err_cnt);
        end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        vld = 1'b0;
        din = 3'b000;
        clr = 1'b0;
        w = 3'b000;
        test_reset();
        test_acquire();
        test_single_hit();
        test_loss();
        test_lockup();
        test_sat_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
